// File: rtl/uart_pkg.sv
// uart_pkg: shared widths, defaults and FSM state type for the UART operand path.
package uart_pkg;
    localparam int BYTE_W             = 8;
    localparam int NUM_BYTES_DEF      = 8;
    localparam int TIMEOUT_CYCLES_DEF = 1000000;
    typedef enum logic [1:0] {IDLE, COLLECT, CHECK, HOLD} rx_pack_state_t;
endpackage

// File: rtl/uart_idle_timer.sv
// uart_idle_timer: counts enabled cycles and strobes expired on the last one.
module uart_idle_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer_q, timer_d;
    assign expired_o = enable_i && timer_q == LAST;
    assign timer_d   = (clear_i || expired_o) ? '0 : enable_i ? timer_q + 1'b1 : timer_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) timer_q <= '0;
        else         timer_q <= timer_d;
    end
endmodule

// File: rtl/uart_rx_word_packer.sv
// uart_rx_word_packer: packs received bytes little-endian into one word with valid/ready output.
// Define UART_RX_CHECKSUM_EN to require a trailing XOR checksum byte per word.
module uart_rx_word_packer
    import uart_pkg::*;
#(
    parameter int NUM_BYTES      = NUM_BYTES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic [BYTE_W-1:0]           rx_byte,
    input  logic                        rx_byte_valid,
    input  logic                        rx_frame_err,
    output logic [BYTE_W*NUM_BYTES-1:0] word_out,
    output logic                        word_valid,
    input  logic                        word_ready,
    output logic                        busy,
    output logic                        timeout_err,
    output logic                        overrun_err,
    output logic                        chk_err
);
    localparam int W     = BYTE_W * NUM_BYTES;
    localparam int CNT_W = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(NUM_BYTES - 1);
    localparam logic [CNT_W-1:0] START_CNT = NUM_BYTES == 1 ? '0 : CNT_W'(1);
`ifdef UART_RX_CHECKSUM_EN
    localparam rx_pack_state_t DONE = CHECK;
`else
    localparam rx_pack_state_t DONE = HOLD;
`endif
    localparam rx_pack_state_t START = NUM_BYTES == 1 ? DONE : COLLECT;

    rx_pack_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]      word_q, word_d;
    logic              valid_q;
    logic              good, bad, expired;
`ifdef UART_RX_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
`endif

    assign good       = rx_byte_valid && !rx_frame_err;
    assign bad        = rx_byte_valid && rx_frame_err;
    assign busy       = state_q == COLLECT || state_q == CHECK;
    assign word_out   = word_q;
    assign word_valid = valid_q;

    uart_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk_i    (sys_clk),
        .rst_ni   (rst),
        .clear_i  (good || !busy),
        .enable_i (busy && !good),
        .expired_o(expired)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        timeout_err = 1'b0;
        overrun_err = 1'b0;
        chk_err     = 1'b0;
`ifdef UART_RX_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            IDLE: if (good) begin
                word_d[BYTE_W-1:0] = rx_byte;
                cnt_d              = START_CNT;
                state_d            = START;
`ifdef UART_RX_CHECKSUM_EN
                csum_d             = rx_byte;
`endif
            end
            COLLECT: if (good) begin
                word_d[cnt_q*BYTE_W +: BYTE_W] = rx_byte;
                cnt_d   = cnt_q == LAST ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == LAST ? DONE : COLLECT;
`ifdef UART_RX_CHECKSUM_EN
                csum_d  = csum_q ^ rx_byte;
`endif
            end else if (bad || expired) begin
                cnt_d       = '0;
                state_d     = IDLE;
                timeout_err = !bad;
            end
            CHECK: begin
`ifdef UART_RX_CHECKSUM_EN
                if (good) begin
                    state_d = rx_byte == csum_q ? HOLD : IDLE;
                    chk_err = rx_byte != csum_q;
                end else if (bad || expired) begin
                    state_d     = IDLE;
                    timeout_err = !bad;
                end
`else
                state_d = IDLE;
`endif
            end
            HOLD: if (valid_q && word_ready) begin
                // A byte coinciding with the handshake starts the next word.
                state_d = good ? START : IDLE;
                if (good) begin
                    word_d[BYTE_W-1:0] = rx_byte;
                    cnt_d              = START_CNT;
`ifdef UART_RX_CHECKSUM_EN
                    csum_d             = rx_byte;
`endif
                end
            end else begin
                overrun_err = good;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
`ifdef UART_RX_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= state_d == HOLD;
`ifdef UART_RX_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_rx_word_packer.sv
// tb_uart_rx_word_packer: directed self-checking bench for the UART word packer.
module tb_uart_rx_word_packer;
    localparam int NB = 8;
    localparam int TO = 100;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rx_byte = '0;
    logic          rx_byte_valid = 1'b0;
    logic          rx_frame_err = 1'b0;
    logic          word_ready = 1'b0;
    logic [63:0]   word_out;
    logic          word_valid, busy, timeout_err, overrun_err, chk_err;
    int            checks = 0;
    int            errors = 0;
    int            n_words = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) if (word_valid && word_ready) n_words <= n_words + 1;

    uart_rx_word_packer #(.NUM_BYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .rx_byte      (rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .rx_frame_err (rx_frame_err),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .overrun_err  (overrun_err),
        .chk_err      (chk_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        rx_frame_err  = e;
        step();
        rx_byte_valid = 1'b0;
        rx_frame_err  = 1'b0;
    endtask

    // Sends bytes first..NB-1 of w (plus the XOR checksum over all of w when enabled).
    task automatic send_word(input logic [63:0] w, input int first);
        logic [7:0] cs;
        cs = '0;
        for (int i = 0; i < NB; i++) begin
            cs ^= w[8*i +: 8];
            if (i >= first) send_byte(w[8*i +: 8], 1'b0);
        end
`ifdef UART_RX_CHECKSUM_EN
        send_byte(cs, 1'b0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int words0, first, pulses;
        logic [63:0] held;
        step();
        step();
        check("rst_word_out", word_out, 64'h0);
        check("rst_word_valid", word_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_errs", {timeout_err, overrun_err, chk_err}, 0);
        rst = 1'b1;
        step();

        word_ready = 1'b1;
        words0 = n_words;
        send_word(64'h0807060504030201, 0);
        check("norm_valid", word_valid, 1);
        check("norm_word", word_out, 64'h0807060504030201);
        step();
        check("norm_valid_drop", word_valid, 0);
        check("norm_count", n_words - words0, 1);

        word_ready = 1'b0;
        send_word(64'h2827262524232221, 0);
        check("bp_valid", word_valid, 1);
        words0 = n_words;
        repeat (20) step();
        rx_byte = 8'h99;
        rx_byte_valid = 1'b1;
        @(negedge sys_clk);
        check("bp_overrun", overrun_err, 1);
        step();
        rx_byte_valid = 1'b0;
        @(negedge sys_clk);
        check("bp_overrun_once", overrun_err, 0);
        repeat (29) step();
        check("bp_word_stable", word_out, 64'h2827262524232221);
        check("bp_valid_held", word_valid, 1);
        check("bp_no_xfer", n_words - words0, 0);
        word_ready = 1'b1;
        step();
        check("bp_xfer", n_words - words0, 1);
        check("bp_valid_drop", word_valid, 0);
        check("bp_idle", busy, 0);

        send_byte(8'hB1, 1'b0);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hB3, 1'b0);
        check("to_busy", busy, 1);
        first = -1;
        pulses = 0;
        for (int j = 0; j < 150; j++) begin
            @(negedge sys_clk);
            if (timeout_err) begin
                pulses++;
                if (first < 0) first = j;
            end
            step();
        end
        check("to_cycle", first, 99);
        check("to_pulses", pulses, 1);
        check("to_busy_fall", busy, 0);
        check("to_no_valid", word_valid, 0);
        send_word(64'hA7A6A5A4A3A2A1A0, 0);
        check("to_next_valid", word_valid, 1);
        check("to_next_word", word_out, 64'hA7A6A5A4A3A2A1A0);
        step();

        words0 = n_words;
        for (int i = 0; i < 4; i++) send_byte(8'hE1 + 8'(i), 1'b0);
        send_byte(8'hEE, 1'b1);
        check("fe_idle", busy, 0);
        check("fe_no_valid", word_valid, 0);
        send_word(64'h1817161514131211, 0);
        check("fe_word", word_out, 64'h1817161514131211);
        step();
        check("fe_one_word", n_words - words0, 1);

        word_ready = 1'b0;
        send_word(64'h3837363534333231, 0);
        check("col_word", word_out, 64'h3837363534333231);
        words0 = n_words;
        word_ready = 1'b1;
        rx_byte = 8'h55;
        rx_byte_valid = 1'b1;
        step();
        rx_byte_valid = 1'b0;
        check("col_xfer", n_words - words0, 1);
        check("col_valid_drop", word_valid, 0);
        check("col_busy", busy, 1);
        send_word(64'h5C5B5A5958575655, 1);
        check("col_next_valid", word_valid, 1);
        check("col_next_word", word_out, 64'h5C5B5A5958575655);
        step();

        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        @(negedge sys_clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_word", word_out, 64'h0);
        step();
        rst = 1'b1;
        step();

`ifdef UART_RX_CHECKSUM_EN
        send_word(64'h0807060504030201, 0);
        check("cs_good_valid", word_valid, 1);
        check("cs_good_word", word_out, 64'h0807060504030201);
        step();
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
        rx_byte = 8'h00;
        rx_byte_valid = 1'b1;
        @(negedge sys_clk);
        check("cs_bad_pulse", chk_err, 1);
        step();
        rx_byte_valid = 1'b0;
        check("cs_bad_no_valid", word_valid, 0);
        check("cs_bad_idle", busy, 0);
`else
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            check("chk_err_tied", chk_err, 0);
            send_byte(8'(i), 1'b0);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
